alu_result_fifo: RTL and testbench

- Consumer-side collector for the ALU result interface: captures each `d_out` word plus the `op` code that produced it.
- Buffers entries in a small FIFO and lets a downstream reader drain them with a read-strobe / registered-data handshake.
- Sits after the ALU, on the opposite end of the operand/op issue path, so results can be checked or forwarded without stalling the issuer.

---
 rtl/alu_result_fifo_if.sv | 44 ++++
 rtl/alu_result_fifo.sv | 100 ++++++++++
 tb/tb_alu_result_fifo.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_result_fifo_if.sv
// Result-collector bus between the ALU consumer side and the downstream reader.
// RESULT_CHECKSUM_EN adds the running csum signal.
interface alu_result_fifo_if #(
  parameter int unsigned DATAW = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             ena;
  logic             in_valid;
  logic [DATAW-1:0] d_in;
  logic [1:0]       op_in;
  logic             in_ready;
  logic             rd_en;
  logic             rd_valid;
  logic [DATAW-1:0] rd_data;
  logic [1:0]       rd_op;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic [7:0]       drop_cnt;
`ifdef RESULT_CHECKSUM_EN
  logic [DATAW-1:0] csum;

  modport master (
    output ena, in_valid, d_in, op_in, rd_en,
    input  in_ready, rd_valid, rd_data, rd_op, count, empty, full, ovf, drop_cnt, csum
  );
  modport slave (
    input  ena, in_valid, d_in, op_in, rd_en,
    output in_ready, rd_valid, rd_data, rd_op, count, empty, full, ovf, drop_cnt, csum
  );
`else
  modport master (
    output ena, in_valid, d_in, op_in, rd_en,
    input  in_ready, rd_valid, rd_data, rd_op, count, empty, full, ovf, drop_cnt
  );
  modport slave (
    input  ena, in_valid, d_in, op_in, rd_en,
    output in_ready, rd_valid, rd_data, rd_op, count, empty, full, ovf, drop_cnt
  );
`endif
endinterface

// File: rtl/alu_result_fifo.sv
// Collects ALU {op, result} pairs into a FIFO drained by a read strobe with registered data.
// Optional RESULT_CHECKSUM_EN keeps a running modular sum of accepted writes on csum.
module alu_result_fifo #(
  parameter int unsigned DATAW = 16,
  parameter int unsigned DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  alu_result_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [DATAW+1:0] mem [DEPTH];

  logic [AW-1:0]    wrPtrQ;
  logic [AW-1:0]    rdPtrQ;
  logic [AW:0]      countQ;
  logic             rdValidQ;
  logic [DATAW-1:0] rdDataQ;
  logic [1:0]       rdOpQ;
  logic             ovfQ;
  logic [7:0]       dropCntQ;

  logic fullS;
  logic emptyS;
  logic wrAcc;
  logic wrDrop;
  logic rdAcc;

  // Full is taken from registered count, so a same-cycle read never rescues a write while full.
  assign fullS  = (countQ == FullCount);
  assign emptyS = (countQ == '0);
  assign wrAcc  = bus.ena & bus.in_valid & ~fullS;
  assign wrDrop = bus.ena & bus.in_valid & fullS;
  assign rdAcc  = bus.rd_en & ~emptyS;

  always_ff @(posedge clk) begin
    if (wrAcc) begin
      mem[wrPtrQ] <= {bus.op_in, bus.d_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrQ   <= '0;
      rdPtrQ   <= '0;
      countQ   <= '0;
      rdValidQ <= 1'b0;
      rdDataQ  <= '0;
      rdOpQ    <= '0;
      ovfQ     <= 1'b0;
      dropCntQ <= '0;
    end else begin
      rdValidQ <= rdAcc;
      if (wrAcc) begin
        wrPtrQ <= wrPtrQ + 1'b1;
      end
      if (rdAcc) begin
        rdPtrQ           <= rdPtrQ + 1'b1;
        {rdOpQ, rdDataQ} <= mem[rdPtrQ];
      end
      unique case ({wrAcc, rdAcc})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
      if (wrDrop) begin
        ovfQ <= 1'b1;
        if (dropCntQ != 8'hFF) begin
          dropCntQ <= dropCntQ + 1'b1;
        end
      end
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [DATAW-1:0] csumQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      csumQ <= '0;
    end else if (wrAcc) begin
      csumQ <= csumQ + bus.d_in + DATAW'(bus.op_in);
    end
  end

  assign bus.csum = csumQ;
`endif

  assign bus.in_ready = ~fullS;
  assign bus.full     = fullS;
  assign bus.empty    = emptyS;
  assign bus.count    = countQ;
  assign bus.rd_valid = rdValidQ;
  assign bus.rd_data  = rdDataQ;
  assign bus.rd_op    = rdOpQ;
  assign bus.ovf      = ovfQ;
  assign bus.drop_cnt = dropCntQ;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed table-driven bench for alu_result_fifo plus hand sequences for saturation and reset.
module tb_alu_result_fifo;
  localparam int unsigned DATAW = 16;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_fifo_if #(.DATAW(DATAW), .DEPTH(DEPTH)) bus ();

  alu_result_fifo #(.DATAW(DATAW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        ena;
    logic        iv;
    logic [15:0] d;
    logic [1:0]  op;
    logic        rden;
    logic        eRdv;
    logic [15:0] eData;
    logic [1:0]  eOp;
    int          eCount;
    logic        eOvf;
    int          eDrop;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nPass   = 0;

  function automatic void add(logic r, logic e, logic iv, logic [15:0] d, logic [1:0] op,
                              logic rden, logic eRdv, logic [15:0] eData, logic [1:0] eOp,
                              int eCount, logic eOvf, int eDrop);
    vec_t v;
    v.rst = r; v.ena = e; v.iv = iv; v.d = d; v.op = op; v.rden = rden;
    v.eRdv = eRdv; v.eData = eData; v.eOp = eOp; v.eCount = eCount;
    v.eOvf = eOvf; v.eDrop = eDrop;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Apply inputs away from the edge, clock once, sample 1 ns after the edge.
  task automatic drive(input logic r, input logic e, input logic iv, input logic [15:0] d,
                       input logic [1:0] op, input logic rden);
    rst = r; bus.ena = e; bus.in_valid = iv; bus.d_in = d; bus.op_in = op; bus.rd_en = rden;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic eRdv, input logic [15:0] eData,
                            input logic [1:0] eOp, input int eCount, input logic eOvf,
                            input int eDrop);
    chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(eRdv));
    chk({tag, " rd_data"},  32'(bus.rd_data),  32'(eData));
    chk({tag, " rd_op"},    32'(bus.rd_op),    32'(eOp));
    chk({tag, " count"},    32'(bus.count),    32'(eCount));
    chk({tag, " empty"},    32'(bus.empty),    32'(eCount == 0));
    chk({tag, " full"},     32'(bus.full),     32'(eCount == DEPTH));
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(eCount != DEPTH));
    chk({tag, " ovf"},      32'(bus.ovf),      32'(eOvf));
    chk({tag, " drop_cnt"}, 32'(bus.drop_cnt), 32'(eDrop));
  endtask

  initial begin
    logic [15:0] hd;
    logic [1:0]  ho;

    rst = 1'b1; bus.ena = 1'b0; bus.in_valid = 1'b0; bus.d_in = '0; bus.op_in = '0;
    bus.rd_en = 1'b0;

    // Reset with every other input active.
    add(1, 1, 1, 16'd99, 2'd1, 1, 0, 16'd0, 2'd0, 0, 0, 0);
    // Basic order.
    add(0, 1, 1, 16'd8888, 2'd0, 0, 0, 16'd0, 2'd0, 1, 0, 0);
    add(0, 1, 1, 16'd2321, 2'd1, 0, 0, 16'd0, 2'd0, 2, 0, 0);
    add(0, 1, 1, 16'd6546, 2'd2, 0, 0, 16'd0, 2'd0, 3, 0, 0);
    add(0, 1, 1, 16'd1123, 2'd3, 0, 0, 16'd0, 2'd0, 4, 0, 0);
    add(0, 0, 0, 16'd0, 2'd0, 1, 1, 16'd8888, 2'd0, 3, 0, 0);
    add(0, 0, 0, 16'd0, 2'd0, 1, 1, 16'd2321, 2'd1, 2, 0, 0);
    add(0, 0, 0, 16'd0, 2'd0, 1, 1, 16'd6546, 2'd2, 1, 0, 0);
    add(0, 0, 0, 16'd0, 2'd0, 1, 1, 16'd1123, 2'd3, 0, 0, 0);
    // Read on empty: nothing pops, data held.
    add(0, 0, 0, 16'd0, 2'd0, 1, 0, 16'd1123, 2'd3, 0, 0, 0);
    // ena gating.
    for (int i = 0; i < 3; i++) add(0, 0, 1, 16'd7, 2'd2, 0, 0, 16'd1123, 2'd3, 0, 0, 0);
    // Fill to full, then one drop.
    for (int i = 1; i <= 8; i++)
      add(0, 1, 1, 16'(i), 2'(i % 4), 0, 0, 16'd1123, 2'd3, i, 0, 0);
    add(0, 1, 1, 16'd9, 2'd1, 0, 0, 16'd1123, 2'd3, 8, 1, 1);
    for (int i = 1; i <= 8; i++)
      add(0, 0, 0, 16'd0, 2'd0, 1, 1, 16'(i), 2'(i % 4), 8 - i, 1, 1);
    // Simultaneous write and read at count 3.
    add(0, 1, 1, 16'd10, 2'd2, 0, 0, 16'd8, 2'd0, 1, 1, 1);
    add(0, 1, 1, 16'd11, 2'd3, 0, 0, 16'd8, 2'd0, 2, 1, 1);
    add(0, 1, 1, 16'd12, 2'd0, 0, 0, 16'd8, 2'd0, 3, 1, 1);
    add(0, 1, 1, 16'd5555, 2'd1, 1, 1, 16'd10, 2'd2, 3, 1, 1);
    add(0, 0, 0, 16'd0, 2'd0, 1, 1, 16'd11, 2'd3, 2, 1, 1);
    add(0, 0, 0, 16'd0, 2'd0, 1, 1, 16'd12, 2'd0, 1, 1, 1);
    add(0, 0, 0, 16'd0, 2'd0, 1, 1, 16'd5555, 2'd1, 0, 1, 1);
    // Wrap: alternating write/read.
    hd = 16'd5555; ho = 2'd1;
    for (int i = 0; i < 20; i++) begin
      add(0, 1, 1, 16'(i), 2'(i % 4), 0, 0, hd, ho, 1, 1, 1);
      add(0, 0, 0, 16'd0, 2'd0, 1, 1, 16'(i), 2'(i % 4), 0, 1, 1);
      hd = 16'(i); ho = 2'(i % 4);
    end

    @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].ena, vecs[k].iv, vecs[k].d, vecs[k].op, vecs[k].rden);
      checkState($sformatf("v%0d", k), vecs[k].eRdv, vecs[k].eData, vecs[k].eOp,
                 vecs[k].eCount, vecs[k].eOvf, vecs[k].eDrop);
    end

    // drop_cnt saturation with contents preserved.
    drive(1, 0, 0, 16'd0, 2'd0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 16'(100 + i), 2'(i % 4), 0);
    checkState("fill", 0, 16'd0, 2'd0, 8, 0, 0);
    for (int i = 0; i < 260; i++) drive(0, 1, 1, 16'hDEAD, 2'd3, 0);
    checkState("sat", 0, 16'd0, 2'd0, 8, 1, 255);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 16'd0, 2'd0, 1);
      checkState($sformatf("satrd%0d", i), 1, 16'(100 + i), 2'(i % 4), 7 - i, 1, 255);
    end

    // Reset mid-operation (count 5, ovf set), with all other inputs active.
    drive(1, 1, 1, 16'h1234, 2'd1, 1);
    checkState("midrst", 0, 16'd0, 2'd0, 0, 0, 0);
`ifdef RESULT_CHECKSUM_EN
    chk("csum reset", 32'(bus.csum), 32'h0);
`endif
    drive(0, 1, 1, 16'd8888, 2'd0, 0);
    drive(0, 1, 1, 16'd5555, 2'd1, 0);
    checkState("postrst wr", 0, 16'd0, 2'd0, 2, 0, 0);
`ifdef RESULT_CHECKSUM_EN
    chk("csum sum", 32'(bus.csum), 32'h386C);
    drive(0, 1, 0, 16'd4000, 2'd2, 0);
    chk("csum no valid", 32'(bus.csum), 32'h386C);
`endif
    drive(0, 0, 0, 16'd0, 2'd0, 1);
    checkState("postrst rd0", 1, 16'd8888, 2'd0, 1, 0, 0);
    drive(0, 0, 0, 16'd0, 2'd0, 1);
    checkState("postrst rd1", 1, 16'd5555, 2'd1, 0, 0, 0);
    drive(0, 0, 0, 16'd0, 2'd0, 0);
    checkState("idle", 0, 16'd5555, 2'd1, 0, 0, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
